// File: rtl/data_unpacker_rb_resp.sv
// Read-response stage: turns tagged FIFO read beats into a keep/last AXI-Stream
// and owns burst abort (forward to requester, discard in-flight beats of that burst).
module data_unpacker_rb_resp #(
   parameter int CHANS         = 4,
   parameter int DATA_WIDTH    = 16 << CHANS,
   parameter int DATA_BITS     = $clog2(CHANS) + 1,
   parameter int DAC_CMD_WIDTH = 1,
   parameter int ID_WIDTH      = DAC_CMD_WIDTH + DATA_BITS + 1,
   parameter int STAT_WIDTH    = 32,
   localparam int LANES        = 2 ** DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    s_fifo_rdata,
   input  logic [ID_WIDTH-1:0]      s_fifo_rid,
   input  logic                     s_fifo_rvalid,
   output logic                     s_fifo_rready,
   input  logic [DAC_CMD_WIDTH-1:0] s_abort_id,
   input  logic                     s_abort_valid,
   output logic                     s_abort_ready,
   output logic [DAC_CMD_WIDTH-1:0] m_abort_id,
   output logic                     m_abort_valid,
   output logic [DATA_WIDTH-1:0]    m_tdata,
   output logic [LANES-1:0]         m_tkeep,
   output logic                     m_tlast,
   output logic [DAC_CMD_WIDTH-1:0] m_tid,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [STAT_WIDTH-1:0]    stat_beats,
   output logic [STAT_WIDTH-1:0]    stat_dropped,
   output logic [STAT_WIDTH-1:0]    stat_bursts,
   output logic                     abort_state
);

   localparam int ENT_W = DAC_CMD_WIDTH + 1 + LANES + DATA_WIDTH;

   typedef enum logic {IDLE = 1'b0, DROP = 1'b1} abort_state_t;

   abort_state_t             state, state_n;
   logic [DAC_CMD_WIDTH-1:0] abort_id_r;
   logic                     abort_pulse_r;
   logic                     abort_ready_r;
   logic                     rready_r;
   logic                     rready_n;
   logic [1:0]               cnt, cnt_n;
   logic [1:0]               wr_idx;
   logic [ENT_W-1:0]         slot   [3];
   logic [ENT_W-1:0]         slot_n [3];
   logic [ENT_W-1:0]         new_ent;
   logic [LANES-1:0]         beat_keep;
   logic [STAT_WIDTH-1:0]    beats_r, dropped_r, bursts_r;

   // Handshakes are strict valid/ready: a transfer happens on a rising clk edge
   // where both are high; valid never waits on ready and ready is always a flop.
   logic                     beat_acc, beat_drop, push, pop, abort_acc;
   logic [DAC_CMD_WIDTH-1:0] beat_cmd;
   logic                     beat_last;
   logic [DATA_BITS-1:0]     beat_n;

   assign beat_cmd  = s_fifo_rid[ID_WIDTH-1:DATA_BITS+1];
   assign beat_last = s_fifo_rid[0];
   assign beat_n    = s_fifo_rid[DATA_BITS:1];
   assign beat_acc  = s_fifo_rvalid & rready_r;
   assign beat_drop = beat_acc & (state == DROP) & (beat_cmd == abort_id_r);
   assign push      = beat_acc & ~beat_drop;
   assign pop       = (cnt != 2'd0) & m_tready;
   assign abort_acc = s_abort_valid & abort_ready_r;

   always_comb begin
      beat_keep = '1;
      if (beat_last && beat_n != '0)
         beat_keep = (LANES'(1) << beat_n) - LANES'(1);
   end

   assign new_ent = {beat_cmd, beat_last, beat_keep, s_fifo_rdata};

   // slot[0] is the output register, slot[1] the overflow register and slot[2]
   // the holding register that only fills while an abort is pending.
   always_comb begin
      slot_n = slot;
      if (pop) begin
         slot_n[0] = slot[1];
         slot_n[1] = slot[2];
      end
      wr_idx = cnt - {1'b0, pop};
      if (push) begin
         case (wr_idx)
            2'd0:    slot_n[0] = new_ent;
            2'd1:    slot_n[1] = new_ent;
            default: slot_n[2] = new_ent;
         endcase
      end
      cnt_n = cnt + {1'b0, push} - {1'b0, pop};
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (abort_acc) state_n = DROP;
         DROP: if (beat_drop && beat_last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // While dropping, ready stays open as long as the holding slot is free so that
   // discarded beats never stall behind a full output buffer.
   assign rready_n = (cnt_n <= 2'd1) | ((state_n == DROP) & (cnt_n <= 2'd2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         abort_id_r    <= '0;
         abort_pulse_r <= 1'b0;
         abort_ready_r <= 1'b0;
         rready_r      <= 1'b0;
         cnt           <= 2'd0;
         slot[0]       <= '0;
         slot[1]       <= '0;
         slot[2]       <= '0;
         beats_r       <= '0;
         dropped_r     <= '0;
         bursts_r      <= '0;
      end else begin
         state         <= state_n;
         abort_pulse_r <= abort_acc;
         abort_ready_r <= (state_n == IDLE);
         rready_r      <= rready_n;
         cnt           <= cnt_n;
         slot[0]       <= slot_n[0];
         slot[1]       <= slot_n[1];
         slot[2]       <= slot_n[2];
         if (abort_acc)
            abort_id_r <= s_abort_id;
         if (pop)
            beats_r <= beats_r + STAT_WIDTH'(1);
         if (pop && slot[0][DATA_WIDTH+LANES])
            bursts_r <= bursts_r + STAT_WIDTH'(1);
         if (beat_drop)
            dropped_r <= dropped_r + STAT_WIDTH'(1);
      end
   end

   assign s_fifo_rready = rready_r;
   assign s_abort_ready = abort_ready_r;
   assign m_abort_valid = abort_pulse_r;
   assign m_abort_id    = abort_id_r;
   assign m_tvalid      = (cnt != 2'd0);
   assign {m_tid, m_tlast, m_tkeep, m_tdata} = slot[0];
   assign stat_beats    = beats_r;
   assign stat_dropped  = dropped_r;
   assign stat_bursts   = bursts_r;
   assign abort_state   = state;

endmodule

// File: tb/tb_data_unpacker_rb_resp.sv
// Bench for data_unpacker_rb_resp: keep/last vector table, directed abort/stall/reset
// sequences and random traffic checked against a queue-based reference model.
module tb_data_unpacker_rb_resp;

   localparam int CHANS = 4;
   localparam int DW    = 16 << CHANS;
   localparam int DB    = $clog2(CHANS) + 1;
   localparam int LANES = 2 ** DB;
   localparam int CW    = 1;
   localparam int IW    = CW + DB + 1;
   localparam int SW    = 32;
   localparam int EW    = CW + 1 + LANES + DW;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_fifo_rdata;
   logic [IW-1:0] s_fifo_rid;
   logic          s_fifo_rvalid;
   logic          s_fifo_rready;
   logic [CW-1:0] s_abort_id;
   logic          s_abort_valid;
   logic          s_abort_ready;
   logic [CW-1:0] m_abort_id;
   logic          m_abort_valid;
   logic [DW-1:0] m_tdata;
   logic [LANES-1:0] m_tkeep;
   logic          m_tlast;
   logic [CW-1:0] m_tid;
   logic          m_tvalid;
   logic          m_tready;
   logic [SW-1:0] stat_beats, stat_dropped, stat_bursts;
   logic          abort_state;

   data_unpacker_rb_resp #(.CHANS(CHANS), .DAC_CMD_WIDTH(CW), .STAT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_fifo_rdata(s_fifo_rdata), .s_fifo_rid(s_fifo_rid),
      .s_fifo_rvalid(s_fifo_rvalid), .s_fifo_rready(s_fifo_rready),
      .s_abort_id(s_abort_id), .s_abort_valid(s_abort_valid), .s_abort_ready(s_abort_ready),
      .m_abort_id(m_abort_id), .m_abort_valid(m_abort_valid),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .stat_beats(stat_beats), .stat_dropped(stat_dropped), .stat_bursts(stat_bursts),
      .abort_state(abort_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   int            model_beats, model_dropped, model_bursts, n_abort_pulses;
   bit            model_pending;
   logic [CW-1:0] model_abort_id;
   bit            exp_abort_now;
   logic [CW-1:0] exp_abort_id;
   bit            seen_rready_low;
   int            rdy_mode;

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LANES-1:0] spec_keep(input bit last, input int n);
      logic [LANES-1:0] k;
      for (int i = 0; i < LANES; i++)
         k[i] = !last || (n == 0) || (i < n);
      return k;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++)
         d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   // Reference model: observes handshakes mid-cycle and predicts the stream.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [EW-1:0] e;
         logic [CW-1:0] cmd;
         int            n;
         bit            last;
         if (m_abort_valid || exp_abort_now) begin
            check("abort_pulse_valid", m_abort_valid, exp_abort_now);
            if (m_abort_valid && exp_abort_now)
               check("abort_pulse_id", m_abort_id, exp_abort_id);
            if (m_abort_valid) n_abort_pulses++;
         end
         exp_abort_now = s_abort_valid && s_abort_ready;
         if (exp_abort_now) exp_abort_id = s_abort_id;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {m_tid, m_tlast, m_tkeep, m_tdata}, '0);
            end else begin
               e = exp_q.pop_front();
               check("stream_beat", {m_tid, m_tlast, m_tkeep, m_tdata}, e);
               model_beats++;
               if (e[DW+LANES]) model_bursts++;
            end
         end
         if (s_fifo_rvalid && !s_fifo_rready) seen_rready_low = 1;
         if (s_fifo_rvalid && s_fifo_rready) begin
            cmd  = s_fifo_rid[IW-1:DB+1];
            n    = int'(s_fifo_rid[DB:1]);
            last = s_fifo_rid[0];
            if (model_pending && cmd == model_abort_id) begin
               model_dropped++;
               if (last) model_pending = 0;
            end else begin
               exp_q.push_back({cmd, last, spec_keep(last, n), s_fifo_rdata});
            end
         end
         if (exp_abort_now) begin
            model_pending  = 1;
            model_abort_id = s_abort_id;
         end
      end
   end

   // ---------------- drivers ----------------
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         2:       m_tready = 1'($urandom_range(0, 1));
         default: m_tready = 1'b0;
      endcase
   end

   task automatic drive_beat(input logic [DW-1:0] d, input logic [CW-1:0] cmd, input bit last, input int n);
      bit acc;
      int guard;
      acc   = 0;
      guard = 0;
      s_fifo_rdata  = d;
      s_fifo_rid    = {cmd, DB'(n), last};
      s_fifo_rvalid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         acc = s_fifo_rready;
         @(posedge clk);
         #1;
         guard++;
         if (!acc && guard > 500) begin
            check("beat_accept_timeout", 0, 1);
            acc = 1;
         end
      end
      s_fifo_rvalid = 1'b0;
   endtask

   task automatic send_burst(input logic [CW-1:0] cmd, input int len, input int n);
      for (int i = 0; i < len; i++)
         drive_beat(rand_data(), cmd, i == len - 1, n);
   endtask

   task automatic do_abort(input logic [CW-1:0] id);
      s_abort_id    = id;
      s_abort_valid = 1'b1;
      @(posedge clk);
      #1;
      s_abort_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || m_tvalid) && g < 1000) begin
         @(posedge clk);
         #1;
         g++;
      end
      idle(2);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_stats();
      check("stat_beats", stat_beats, model_beats);
      check("stat_dropped", stat_dropped, model_dropped);
      check("stat_bursts", stat_bursts, model_bursts);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit               last;
      int               n;
      logic [LANES-1:0] keep;
      bit               tlast;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b_beats, b_drop, b_bursts, b_pulses;

      vecs[0] = '{last: 1'b0, n: 0, keep: 8'hFF, tlast: 1'b0};
      vecs[1] = '{last: 1'b0, n: 5, keep: 8'hFF, tlast: 1'b0};
      vecs[2] = '{last: 1'b1, n: 0, keep: 8'hFF, tlast: 1'b1};
      vecs[3] = '{last: 1'b1, n: 1, keep: 8'h01, tlast: 1'b1};
      vecs[4] = '{last: 1'b1, n: 3, keep: 8'h07, tlast: 1'b1};
      vecs[5] = '{last: 1'b1, n: 7, keep: 8'h7F, tlast: 1'b1};

      rst_n = 1'b0;
      s_fifo_rdata = '0; s_fifo_rid = '0; s_fifo_rvalid = 1'b0;
      s_abort_id = '0; s_abort_valid = 1'b0;
      m_tready = 1'b0; rdy_mode = 0;
      model_beats = 0; model_dropped = 0; model_bursts = 0; n_abort_pulses = 0;
      model_pending = 0; model_abort_id = '0; exp_abort_now = 0; exp_abort_id = '0;
      seen_rready_low = 0;

      idle(3);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_rready", s_fifo_rready, 0);
      check("rst_abort_ready", s_abort_ready, 0);
      check("rst_abort_valid", m_abort_valid, 0);
      check_stats();

      rst_n = 1'b1;
      idle(1);
      check("post_rst_rready", s_fifo_rready, 1);
      check("post_rst_abort_ready", s_abort_ready, 1);

      // keep/last mapping, one beat per vector, one-cycle latency
      foreach (vecs[i]) begin
         logic [DW-1:0] d;
         d = rand_data();
         drive_beat(d, 1'b0, vecs[i].last, vecs[i].n);
         check("tbl_tvalid", m_tvalid, 1);
         check("tbl_tkeep", m_tkeep, vecs[i].keep);
         check("tbl_tlast", m_tlast, vecs[i].tlast);
         check("tbl_tdata", m_tdata, d);
      end
      drain();
      check_stats();

      // 4-beat burst, free-flowing output
      b_beats = model_beats; b_bursts = model_bursts;
      send_burst(1'b0, 4, 3);
      drain();
      check("t1_beats", stat_beats, b_beats + 4);
      check("t1_bursts", stat_bursts, b_bursts + 1);

      // toggling ready: buffer fills and ready drops
      rdy_mode = 1;
      seen_rready_low = 0;
      send_burst(1'b0, 8, 3);
      rdy_mode = 0;
      drain();
      check("t2_rready_dropped", seen_rready_low, 1);
      check_stats();

      // abort cmd 1 after two beats forwarded
      send_burst(1'b1, 0, 0);
      drive_beat(rand_data(), 1'b1, 1'b0, 0);
      drive_beat(rand_data(), 1'b1, 1'b0, 0);
      drain();
      b_drop = model_dropped; b_bursts = model_bursts; b_pulses = n_abort_pulses;
      do_abort(1'b1);
      check("t3_abort_ready_low", s_abort_ready, 0);
      send_burst(1'b1, 4, 2);
      drain();
      check("t3_dropped", stat_dropped, b_drop + 4);
      check("t3_no_tlast", stat_bursts, b_bursts);
      check("t3_pulses", n_abort_pulses, b_pulses + 1);
      check("t3_abort_ready_back", s_abort_ready, 1);

      // abort cmd 1 with cmd 0 interleaved
      b_drop = model_dropped; b_beats = model_beats;
      do_abort(1'b1);
      for (int i = 0; i < 4; i++) begin
         drive_beat(rand_data(), 1'b0, i == 3, 2);
         drive_beat(rand_data(), 1'b1, i == 3, 0);
      end
      drain();
      check("t4_dropped", stat_dropped, b_drop + 4);
      check("t4_beats", stat_beats, b_beats + 4);
      check_stats();

      // second abort while dropping is ignored
      b_pulses = n_abort_pulses;
      do_abort(1'b0);
      check("t5_abort_ready_low", s_abort_ready, 0);
      do_abort(1'b1);
      idle(3);
      check("t5_single_pulse", n_abort_pulses, b_pulses + 1);
      send_burst(1'b0, 2, 0);
      idle(2);
      check("t5_abort_ready_back", s_abort_ready, 1);
      drain();
      check_stats();

      // asynchronous reset mid-burst with a stalled output
      rdy_mode = 3;
      idle(1);
      drive_beat(rand_data(), 1'b0, 1'b0, 0);
      drive_beat(rand_data(), 1'b0, 1'b0, 0);
      check("t6_tvalid_before", m_tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_tvalid", m_tvalid, 0);
      check("t6_async_rready", s_fifo_rready, 0);
      check("t6_async_beats", stat_beats, 0);
      exp_q.delete();
      model_beats = 0; model_dropped = 0; model_bursts = 0;
      model_pending = 0; exp_abort_now = 0;
      idle(2);
      rst_n = 1'b1;
      rdy_mode = 0;
      idle(1);
      send_burst(1'b1, 3, 1);
      drain();
      check("t6_beats", stat_beats, 3);
      check("t6_bursts", stat_bursts, 1);

      // random traffic with random back-pressure and aborts
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0)
            do_abort(CW'($urandom_range(0, 1)));
         else if (r == 1)
            idle($urandom_range(1, 3));
         else
            drive_beat(rand_data(), CW'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, LANES - 1));
      end
      rdy_mode = 0;
      drain();
      check_stats();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
